// File: rtl/rom_mapper_detect.sv
// MSX cartridge mapper detector: sizes the streamed image and votes on bank-switch write addresses; ROM_HEADER_CHECK_EN adds an "AB" header check.
// Latency: result registered in DECIDE; loaded rises 2 cycles after ioctl_download falls.
// Backpressure: none; every ioctl_wr byte is consumed in the cycle it is strobed.
module rom_mapper_detect #(
  parameter int VOTE_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [24:0] rom_size,
  output logic [5:0]  rom_mapper,
  output logic        loaded,
  output logic        busy
);

  typedef enum logic [5:0] {
    MAPPER_NO_UNKNOWN = 6'd0,
    MAPPER_ASCII8     = 6'd1,
    MAPPER_ASCII16    = 6'd2,
    MAPPER_KONAMI     = 6'd3,
    MAPPER_KONAMI_SCC = 6'd4,
    MAPPER_LINEAR     = 6'd5
  } mapper_typ_t;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;
  typedef enum logic [1:0] {P0, P1, P2} pat_t;

  localparam int V_SCC = 0;
  localparam int V_KON = 1;
  localparam int V_A8  = 2;
  localparam int V_A16 = 3;
  localparam logic [VOTE_W-1:0] VOTE_MAX = '1;

  state_t            state, state_nx;
  pat_t              pat, pat_base;
  logic              dl_q;
  logic              dl_rise;
  logic              byte_en;
  logic [7:0]        addr_lo;
  logic [VOTE_W-1:0] votes [4];
  logic [VOTE_W-1:0] vote_base [4];
  logic [3:0]        vote_inc;
  logic [24:0]       size_base;
  logic [24:0]       addr_p1;
  logic [VOTE_W-1:0] best_v;
  mapper_typ_t       best_map;
  mapper_typ_t       decide_map;
  mapper_typ_t       map_q;
`ifdef ROM_HEADER_CHECK_EN
  logic              hdr_lo_ok;
  logic              hdr_hi_ok;
`endif

  assign dl_rise = ioctl_download & ~dl_q;
  // The byte strobed on the rising edge already belongs to the new image.
  assign byte_en = ioctl_wr & ioctl_download & (dl_rise | (state == SCAN));
  assign addr_p1 = ioctl_addr + 25'd1;
  assign rom_mapper = map_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (dl_rise) begin
      state_nx = SCAN;
    end else begin
      case (state)
        SCAN:    if (!ioctl_download) state_nx = DECIDE;
        DECIDE:  state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    busy   = (state == SCAN) || (state == DECIDE);
    loaded = (state == DONE) && (rom_size != '0);
  end

  // A rising edge restarts everything, so the first byte works from cleared state.
  always_comb begin
    pat_base  = dl_rise ? P0 : pat;
    size_base = dl_rise ? '0 : rom_size;
    for (int i = 0; i < 4; i++) vote_base[i] = dl_rise ? '0 : votes[i];
  end

  always_comb begin
    vote_inc = 4'b0000;
    if (byte_en && (pat_base == P2)) begin
      case ({ioctl_dout, addr_lo})
        16'h5000, 16'h9000, 16'hB000: vote_inc = 4'b0001;
        16'h8000, 16'hA000:           vote_inc = 4'b0010;
        16'h6800, 16'h7800:           vote_inc = 4'b0100;
        16'h6000:                     vote_inc = 4'b1100;
        16'h7000:                     vote_inc = 4'b1101;
        16'h77FF:                     vote_inc = 4'b1000;
        default:                      vote_inc = 4'b0000;
      endcase
    end
  end

  // Strict '>' keeps the earlier candidate on ties: SCC > KONAMI > ASCII8 > ASCII16.
  always_comb begin
    best_map = MAPPER_KONAMI_SCC;
    best_v   = votes[V_SCC];
    if (votes[V_KON] > best_v) begin best_map = MAPPER_KONAMI;  best_v = votes[V_KON]; end
    if (votes[V_A8]  > best_v) begin best_map = MAPPER_ASCII8;  best_v = votes[V_A8];  end
    if (votes[V_A16] > best_v) begin best_map = MAPPER_ASCII16; best_v = votes[V_A16]; end
    if (rom_size == '0)             decide_map = MAPPER_NO_UNKNOWN;
    else if (rom_size <= 25'd65536) decide_map = MAPPER_LINEAR;
    else if (best_v == '0)          decide_map = MAPPER_NO_UNKNOWN;
    else                            decide_map = best_map;
`ifdef ROM_HEADER_CHECK_EN
    if (!(hdr_lo_ok && hdr_hi_ok)) decide_map = MAPPER_NO_UNKNOWN;
`endif
  end

  // dl_q follows the pin during reset so a download held high across reset is not a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q     <= ioctl_download;
      pat      <= P0;
      addr_lo  <= '0;
      rom_size <= '0;
      map_q    <= MAPPER_NO_UNKNOWN;
      for (int i = 0; i < 4; i++) votes[i] <= '0;
    end else begin
      dl_q     <= ioctl_download;
      pat      <= pat_base;
      rom_size <= size_base;
      if (byte_en) begin
        if (addr_p1 > size_base) rom_size <= addr_p1;
        case (pat_base)
          P0:      if (ioctl_dout == 8'h32) pat <= P1;
          P1:      begin addr_lo <= ioctl_dout; pat <= P2; end
          default: pat <= P0;
        endcase
      end
      for (int i = 0; i < 4; i++) begin
        if (vote_inc[i] && (vote_base[i] != VOTE_MAX)) votes[i] <= vote_base[i] + 1'b1;
        else                                           votes[i] <= vote_base[i];
      end
      if (dl_rise)                map_q <= MAPPER_NO_UNKNOWN;
      else if (state == DECIDE)   map_q <= decide_map;
    end
  end

`ifdef ROM_HEADER_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || dl_rise) begin
      hdr_lo_ok <= 1'b0;
      hdr_hi_ok <= 1'b0;
    end
    if (!reset && byte_en) begin
      if (ioctl_addr == 25'd0) hdr_lo_ok <= (ioctl_dout == 8'h41);
      if (ioctl_addr == 25'd1) hdr_hi_ok <= (ioctl_dout == 8'h42);
    end
  end
`endif

endmodule
